lime_io_port: RTL and testbench

Host-side I/O port for the 16-bit multicycle processor. It sits on the other end of the processor's `main_input`/`main_output` pins. It captures every change of the processor's output word into a FIFO and drains it to the host over a valid/ready stream. It also accepts host words over a second valid/ready stream and holds each one on the processor's input pin long enough for a multicycle instruction to sample it.

---
 rtl/lime_io_port.sv | 92 +++++++++
 tb/tb_lime_io_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lime_io_port.sv
// Host-side I/O port: captures processor output changes into a show-ahead FIFO for the host,
// and holds host words on the processor input for a minimum number of cycles.
module lime_io_port #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [15:0]            proc_output,
  output logic [15:0]            proc_input,
  input  logic                   host_in_valid,
  output logic                   host_in_ready,
  input  logic [15:0]            host_in_data,
  output logic                   host_out_valid,
  input  logic                   host_out_ready,
  output logic [15:0]            host_out_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  typedef enum logic {IDLE, HOLD} in_state_t;

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [15:0]            last_seen;
  logic                   push_req, push, pop;
  in_state_t              in_state;
  logic [CW-1:0]          hold_cnt;

  // Only edges of the processor output are captured; a full FIFO still accepts when it drains this cycle.
  assign push_req = (proc_output != last_seen);
  assign pop      = host_out_valid && host_out_ready;
  assign push     = push_req && ((fifo_count < FULL) || pop);

  assign host_out_valid = (fifo_count != '0);
  assign host_out_data  = host_out_valid ? mem[rd_ptr] : 16'h0000;
  assign host_in_ready  = (in_state == IDLE);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_seen  <= 16'h0000;
      overflow   <= 1'b0;
    end else begin
      if (push_req) last_seen <= proc_output;
      if (push) begin
        mem[wr_ptr] <= proc_output;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
      // A drop in the same cycle as a clear must stay visible.
      if (push_req && !push) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      in_state   <= IDLE;
      hold_cnt   <= '0;
      proc_input <= 16'h0000;
    end else begin
      case (in_state)
        IDLE: if (host_in_valid) begin
          proc_input <= host_in_data;
          hold_cnt   <= HOLD_MAX;
          in_state   <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) in_state <= IDLE;
          else                hold_cnt <= hold_cnt - HOLD_ONE;
        end
        default: in_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lime_io_port.sv
// Bench for lime_io_port: vector table for the streaming path, scoreboard for every host-side pop,
// and directed sequences for overflow, wrap, input hold and async reset.
module tb_lime_io_port;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] proc_output, proc_input, host_in_data, host_out_data;
  logic        host_in_valid, host_in_ready, host_out_valid, host_out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        overflow, clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  lime_io_port #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .Reset(Reset), .proc_output(proc_output), .proc_input(proc_input),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Every handshake the host sees is checked against the queue of words the stimulus expects.
  always @(negedge CLK) begin
    if (Reset && host_out_valid && host_out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", {16'h0, host_out_data}, 32'hFFFF_FFFF);
      else chk("sb_data", {16'h0, host_out_data}, {16'h0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] po;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    int          ec;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0001, 1'b1, 1'b1, 16'h0001, 1};
    vecs[1] = '{16'h0001, 1'b1, 1'b0, 16'h0000, 0};
    vecs[2] = '{16'h00A5, 1'b1, 1'b1, 16'h00A5, 1};
    vecs[3] = '{16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 1};
    vecs[4] = '{16'hBEEF, 1'b1, 1'b0, 16'h0000, 0};

    Reset = 1'b0; proc_output = '0; host_in_valid = 0; host_in_data = '0;
    host_out_ready = 0; clr_overflow = 0;
    #1;
    chk("rst_proc_input", proc_input, 0);
    chk("rst_in_ready", host_in_ready, 1);
    chk("rst_out_valid", host_out_valid, 0);
    chk("rst_out_data", host_out_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    step(); step();
    Reset = 1'b1;

    // Static zero output: nothing should ever be queued.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_valid", host_out_valid, 0);
      chk("idle_count", fifo_count, 0);
      chk("idle_proc_input", proc_input, 0);
    end

    exp_q.push_back(16'h0001); exp_q.push_back(16'h00A5); exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      proc_output = vecs[i].po; host_out_ready = vecs[i].rdy;
      step();
      chk("vec_valid", host_out_valid, vecs[i].ev);
      chk("vec_data", host_out_data, vecs[i].ed);
      chk("vec_count", fifo_count, vecs[i].ec);
    end
    host_out_ready = 0;
    step();

    // Five distinct changes into a depth-4 FIFO with no drain.
    for (int i = 1; i <= 5; i++) begin
      proc_output = 16'h1000 + 16'(i);
      if (i <= 4) exp_q.push_back(proc_output);
      step();
      chk("ovf_count", fifo_count, (i <= 4) ? i : 4);
      chk("ovf_flag", overflow, (i == 5) ? 1 : 0);
    end
    host_out_ready = 1;
    repeat (4) step();
    chk("ovf_drained_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);
    host_out_ready = 0; clr_overflow = 1;
    step();
    clr_overflow = 0;
    chk("ovf_cleared", overflow, 0);

    // Fill, then push and pop together every cycle across several pointer wraps.
    for (int i = 1; i <= 4; i++) begin
      proc_output = 16'h2000 + 16'(i);
      exp_q.push_back(proc_output);
      step();
    end
    chk("full_count", fifo_count, 4);
    host_out_ready = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      proc_output = 16'h3000 + 16'(i);
      exp_q.push_back(proc_output);
      step();
      chk("wrap_count", fifo_count, 4);
      chk("wrap_overflow", overflow, 0);
    end
    repeat (4) step();
    chk("wrap_drained", fifo_count, 0);
    chk("wrap_sb_empty", exp_q.size(), 0);
    host_out_ready = 0;

    // Host input hold: second word waits until the port is ready again.
    chk("hold_ready_pre", host_in_ready, 1);
    host_in_valid = 1; host_in_data = 16'h1234;
    step();
    chk("hold_pi0", proc_input, 16'h1234);
    chk("hold_rdy0", host_in_ready, 0);
    host_in_data = 16'h5678;
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk("hold_pi", proc_input, 16'h1234);
      chk("hold_rdy", host_in_ready, 0);
    end
    step();
    chk("hold_rdy_back", host_in_ready, 1);
    chk("hold_pi_last", proc_input, 16'h1234);
    step();
    chk("hold_pi_next", proc_input, 16'h5678);
    chk("hold_rdy_next", host_in_ready, 0);
    host_in_valid = 0;
    repeat (HOLD) step();
    chk("hold_idle", host_in_ready, 1);

    // Async reset while holding a word and with two FIFO entries.
    host_in_valid = 1; host_in_data = 16'h4242; proc_output = 16'h4001;
    step();
    host_in_valid = 0; proc_output = 16'h4002;
    step();
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_ready", host_in_ready, 0);
    #2;
    Reset = 0;
    #1;
    chk("arst_proc_input", proc_input, 0);
    chk("arst_in_ready", host_in_ready, 1);
    chk("arst_out_valid", host_out_valid, 0);
    chk("arst_out_data", host_out_data, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_overflow", overflow, 0);
    proc_output = 16'h0000;
    step();
    Reset = 1;
    step();
    chk("post_rst_quiet", fifo_count, 0);
    proc_output = 16'h5555; host_out_ready = 1;
    exp_q.push_back(16'h5555);
    step();
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_data", host_out_data, 16'h5555);
    step();
    chk("post_rst_drained", fifo_count, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
